// File: rtl/fifo_sync_wconv.sv
// Single-clock FIFO with integer-ratio width conversion and first-word-fall-through read.
// Storage entries are max(WR_WIDTH, RD_WIDTH) wide; packing or unpacking happens at the edges.
module fifo_sync_wconv #(
    parameter int DEPTH             = 64,
    parameter int WR_WIDTH          = 32,
    parameter int RD_WIDTH          = 32,
    parameter int PROG_FULL_THRESH  = 48,
    parameter int PROG_EMPTY_THRESH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    wr_en,
    input  logic [WR_WIDTH-1:0]     din,
    output logic                    full,
    input  logic                    rd_en,
    output logic [RD_WIDTH-1:0]     dout,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    prog_full,
    output logic                    prog_empty,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int MEM_W = (WR_WIDTH > RD_WIDTH) ? WR_WIDTH : RD_WIDTH;
    localparam int MIN_W = (WR_WIDTH > RD_WIDTH) ? RD_WIDTH : WR_WIDTH;
    localparam int RATIO = MEM_W / MIN_W;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int SW    = (RATIO > 1) ? $clog2(RATIO) : 1;

    logic [MEM_W-1:0]    mem [DEPTH];

    logic [AW-1:0]       wr_ptr_q;
    logic [AW-1:0]       rd_ptr_q;
    logic [CW-1:0]       count_q;
    logic [CW-1:0]       count_d;
    logic                full_q;
    logic                empty_q;
    logic                prog_full_q;
    logic                prog_empty_q;
    logic                overflow_q;
    logic                underflow_q;

    logic                wr_acc;
    logic                rd_acc;
    logic                push;
    logic                pop;
    logic [MEM_W-1:0]    push_data;
    logic [MEM_W-1:0]    head;
    logic [RD_WIDTH-1:0] head_word;

    assign wr_acc = wr_en & ~full_q;
    assign rd_acc = rd_en & ~empty_q;
    assign head   = mem[rd_ptr_q];

    generate
        if (WR_WIDTH < RD_WIDTH) begin : g_up
            // Holds the first RATIO-1 words; the last word goes straight into memory with them.
            logic [MEM_W-WR_WIDTH-1:0] stage_q;
            logic [MEM_W-WR_WIDTH-1:0] stage_d;
            logic [SW-1:0]             widx_q;
            logic [SW-1:0]             widx_d;

            assign push_data = {din, stage_q};
            assign pop       = rd_acc;
            assign head_word = head;

            always_comb begin
                stage_d = stage_q;
                widx_d  = widx_q;
                push    = 1'b0;
                if (wr_acc) begin
                    if (widx_q == SW'(RATIO - 1)) begin
                        push   = 1'b1;
                        widx_d = '0;
                    end else begin
                        stage_d[widx_q*WR_WIDTH +: WR_WIDTH] = din;
                        widx_d = widx_q + SW'(1);
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stage_q <= '0;
                    widx_q  <= '0;
                end else if (flush) begin
                    stage_q <= '0;
                    widx_q  <= '0;
                end else begin
                    stage_q <= stage_d;
                    widx_q  <= widx_d;
                end
            end
        end else if (WR_WIDTH > RD_WIDTH) begin : g_dn
            // Slice index into the head entry; the entry is popped with its last slice.
            logic [SW-1:0] sidx_q;
            logic [SW-1:0] sidx_d;

            assign push      = wr_acc;
            assign push_data = din;
            assign head_word = head[sidx_q*RD_WIDTH +: RD_WIDTH];

            always_comb begin
                sidx_d = sidx_q;
                pop    = 1'b0;
                if (rd_acc) begin
                    if (sidx_q == SW'(RATIO - 1)) begin
                        pop    = 1'b1;
                        sidx_d = '0;
                    end else begin
                        sidx_d = sidx_q + SW'(1);
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sidx_q <= '0;
                end else if (flush) begin
                    sidx_q <= '0;
                end else begin
                    sidx_q <= sidx_d;
                end
            end
        end else begin : g_eq
            assign push      = wr_acc;
            assign push_data = din;
            assign pop       = rd_acc;
            assign head_word = head;
        end
    endgenerate

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Memory is deliberately left out of reset; empty gating keeps stale data off dout.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            prog_full_q  <= 1'b0;
            prog_empty_q <= 1'b1;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else if (flush) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            prog_full_q  <= 1'b0;
            prog_empty_q <= 1'b1;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q      <= count_d;
            full_q       <= (count_d == CW'(DEPTH));
            empty_q      <= (count_d == '0);
            prog_full_q  <= (count_d >= CW'(PROG_FULL_THRESH));
            prog_empty_q <= (count_d <= CW'(PROG_EMPTY_THRESH));
            overflow_q   <= overflow_q  | (wr_en & full_q);
            underflow_q  <= underflow_q | (rd_en & empty_q);
        end
    end

    assign full       = full_q;
    assign empty      = empty_q;
    assign count      = count_q;
    assign prog_full  = prog_full_q;
    assign prog_empty = prog_empty_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;
    assign dout       = empty_q ? '0 : head_word;

endmodule

// File: tb/tb_fifo_sync_wconv.sv
// Bench for fifo_sync_wconv: equal-width, upsize and downsize instances checked against
// a word-queue model every cycle, plus directed literal expectations.
module tb_fifo_sync_wconv;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    logic         rst_a [3];
    logic         fl_a  [3];
    logic         we_a  [3];
    logic         re_a  [3];
    logic [127:0] din_a [3];

    logic         o_full [3];
    logic         o_empty[3];
    logic         o_pf   [3];
    logic         o_pe   [3];
    logic         o_ov   [3];
    logic         o_un   [3];
    logic [7:0]   o_cnt  [3];
    logic [127:0] o_dout [3];

    logic [6:0]   cnt0;
    logic [2:0]   cnt1;
    logic [3:0]   cnt2;
    logic [31:0]  dout0;
    logic [127:0] dout1;
    logic [31:0]  dout2;

    fifo_sync_wconv #(.DEPTH(64), .WR_WIDTH(32), .RD_WIDTH(32),
                      .PROG_FULL_THRESH(48), .PROG_EMPTY_THRESH(4)) u_eq (
        .clk(clk), .rst_n(rst_a[0]), .flush(fl_a[0]), .wr_en(we_a[0]), .din(din_a[0][31:0]),
        .full(o_full[0]), .rd_en(re_a[0]), .dout(dout0), .empty(o_empty[0]), .count(cnt0),
        .prog_full(o_pf[0]), .prog_empty(o_pe[0]), .overflow(o_ov[0]), .underflow(o_un[0]));

    fifo_sync_wconv #(.DEPTH(4), .WR_WIDTH(32), .RD_WIDTH(128),
                      .PROG_FULL_THRESH(3), .PROG_EMPTY_THRESH(1)) u_up (
        .clk(clk), .rst_n(rst_a[1]), .flush(fl_a[1]), .wr_en(we_a[1]), .din(din_a[1][31:0]),
        .full(o_full[1]), .rd_en(re_a[1]), .dout(dout1), .empty(o_empty[1]), .count(cnt1),
        .prog_full(o_pf[1]), .prog_empty(o_pe[1]), .overflow(o_ov[1]), .underflow(o_un[1]));

    fifo_sync_wconv #(.DEPTH(8), .WR_WIDTH(128), .RD_WIDTH(32),
                      .PROG_FULL_THRESH(6), .PROG_EMPTY_THRESH(2)) u_dn (
        .clk(clk), .rst_n(rst_a[2]), .flush(fl_a[2]), .wr_en(we_a[2]), .din(din_a[2]),
        .full(o_full[2]), .rd_en(re_a[2]), .dout(dout2), .empty(o_empty[2]), .count(cnt2),
        .prog_full(o_pf[2]), .prog_empty(o_pe[2]), .overflow(o_ov[2]), .underflow(o_un[2]));

    assign o_cnt[0]  = {1'b0, cnt0};
    assign o_cnt[1]  = {5'b0, cnt1};
    assign o_cnt[2]  = {4'b0, cnt2};
    assign o_dout[0] = {96'b0, dout0};
    assign o_dout[1] = dout1;
    assign o_dout[2] = {96'b0, dout2};

    function automatic int p_depth(int d);
        case (d) 0: return 64; 1: return 4; default: return 8; endcase
    endfunction
    function automatic int p_wr(int d);
        case (d) 2: return 128; default: return 32; endcase
    endfunction
    function automatic int p_rd(int d);
        case (d) 1: return 128; default: return 32; endcase
    endfunction
    function automatic int p_pf(int d);
        case (d) 0: return 48; 1: return 3; default: return 6; endcase
    endfunction
    function automatic int p_pe(int d);
        case (d) 0: return 4; 1: return 1; default: return 2; endcase
    endfunction
    function automatic logic [127:0] wmask(int w);
        if (w >= 128) return '1;
        return (128'd1 << w) - 128'd1;
    endfunction

    // Model: a queue of read-width words plus a pending write-word accumulator.
    logic [127:0] mq   [3][256];
    int           mh   [3];
    int           mn   [3];
    logic [127:0] pacc [3];
    int           pcnt [3];
    bit           movf [3];
    bit           munf [3];

    function automatic int m_count(int d);
        int r;
        if (p_wr(d) > p_rd(d)) begin
            r = p_wr(d) / p_rd(d);
            return (mn[d] + r - 1) / r;
        end
        return mn[d];
    endfunction

    task automatic m_clear(int d);
        mh[d] = 0; mn[d] = 0; pacc[d] = '0; pcnt[d] = 0; movf[d] = 0; munf[d] = 0;
    endtask

    task automatic m_push(int d, logic [127:0] v);
        mq[d][(mh[d] + mn[d]) % 256] = v;
        mn[d] = mn[d] + 1;
    endtask

    task automatic m_step(int d);
        int c;
        bit f;
        bit e;
        logic [127:0] w;
        c = m_count(d);
        f = (c == p_depth(d));
        e = (c == 0);
        w = din_a[d] & wmask(p_wr(d));
        if (fl_a[d]) begin
            m_clear(d);
            return;
        end
        if (we_a[d] && f) movf[d] = 1;
        if (re_a[d] && e) munf[d] = 1;
        if (re_a[d] && !e) begin
            mh[d] = (mh[d] + 1) % 256;
            mn[d] = mn[d] - 1;
        end
        if (we_a[d] && !f) begin
            if (p_wr(d) == p_rd(d)) begin
                m_push(d, w);
            end else if (p_wr(d) < p_rd(d)) begin
                pacc[d] = pacc[d] | (w << (pcnt[d] * p_wr(d)));
                pcnt[d] = pcnt[d] + 1;
                if (pcnt[d] == p_rd(d) / p_wr(d)) begin
                    m_push(d, pacc[d]);
                    pacc[d] = '0;
                    pcnt[d] = 0;
                end
            end else begin
                for (int i = 0; i < p_wr(d) / p_rd(d); i++)
                    m_push(d, (w >> (i * p_rd(d))) & wmask(p_rd(d)));
            end
        end
    endtask

    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (!rst_a[d]) m_clear(d);
            else m_step(d);
        end
    end

    task automatic chk(string name, int d, logic [127:0] act, logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d t=%0t actual=%0h required=%0h", name, d, $time, act, exp);
        end
    endtask

    task automatic compare_dut(int d);
        int c;
        c = m_count(d);
        if (!rst_a[d]) begin
            chk("rst_full", d, 128'(o_full[d]), 128'd0);
            chk("rst_empty", d, 128'(o_empty[d]), 128'd1);
            chk("rst_count", d, 128'(o_cnt[d]), 128'd0);
            chk("rst_pf", d, 128'(o_pf[d]), 128'd0);
            chk("rst_pe", d, 128'(o_pe[d]), 128'd1);
            chk("rst_ov", d, 128'(o_ov[d]), 128'd0);
            chk("rst_un", d, 128'(o_un[d]), 128'd0);
            chk("rst_dout", d, o_dout[d], 128'd0);
        end else begin
            chk("full", d, 128'(o_full[d]), 128'(c == p_depth(d)));
            chk("empty", d, 128'(o_empty[d]), 128'(c == 0));
            chk("count", d, 128'(o_cnt[d]), 128'(c));
            chk("prog_full", d, 128'(o_pf[d]), 128'(c >= p_pf(d)));
            chk("prog_empty", d, 128'(o_pe[d]), 128'(c <= p_pe(d)));
            chk("overflow", d, 128'(o_ov[d]), 128'(movf[d]));
            chk("underflow", d, 128'(o_un[d]), 128'(munf[d]));
            chk("dout", d, o_dout[d], (c == 0) ? 128'd0 : mq[d][mh[d]]);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int d = 0; d < 3; d++) compare_dut(d);
        end
    end

    task automatic cyc(int d, bit we, bit re, logic [127:0] din, bit fl);
        we_a[d] = we; re_a[d] = re; din_a[d] = din; fl_a[d] = fl;
        @(posedge clk);
        #1;
        we_a[d] = 0; re_a[d] = 0; fl_a[d] = 0;
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst_a[d] = 0; fl_a[d] = 0; we_a[d] = 0; re_a[d] = 0; din_a[d] = '0;
            m_clear(d);
        end
        @(posedge clk); #1;
        cmp_en = 1;
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) rst_a[d] = 1;
        @(posedge clk); #1;

        // Equal width: fill, overflow, drain
        for (int i = 1; i <= 64; i++) begin
            cyc(0, 1, 0, 128'(i), 0);
            if (i == 47) chk("lit_pf_47", 0, 128'(o_pf[0]), 128'd0);
            if (i == 48) chk("lit_pf_48", 0, 128'(o_pf[0]), 128'd1);
            if (i == 63) chk("lit_full_63", 0, 128'(o_full[0]), 128'd0);
        end
        chk("lit_count_64", 0, 128'(cnt0), 128'd64);
        chk("lit_full_64", 0, 128'(o_full[0]), 128'd1);
        cyc(0, 1, 0, 128'hDEAD, 0);
        chk("lit_ovf", 0, 128'(o_ov[0]), 128'd1);
        chk("lit_count_ovf", 0, 128'(cnt0), 128'd64);
        for (int i = 1; i <= 64; i++) begin
            chk("lit_drain", 0, 128'(dout0), 128'(i));
            cyc(0, 0, 1, '0, 0);
            if (i == 59) chk("lit_pe_5", 0, 128'(o_pe[0]), 128'd0);
            if (i == 60) chk("lit_pe_4", 0, 128'(o_pe[0]), 128'd1);
        end
        chk("lit_empty_end", 0, 128'(o_empty[0]), 128'd1);

        // Simultaneous read/write at empty, then at full
        cyc(0, 1, 1, 128'h77, 0);
        chk("lit_unf", 0, 128'(o_un[0]), 128'd1);
        chk("lit_count_1", 0, 128'(cnt0), 128'd1);
        chk("lit_dout_77", 0, 128'(dout0), 128'h77);
        cyc(0, 0, 0, '0, 1);
        for (int i = 0; i < 64; i++) cyc(0, 1, 0, 128'(32'h100 + i), 0);
        cyc(0, 1, 1, 128'hBEEF, 0);
        chk("lit_ovf_rw", 0, 128'(o_ov[0]), 128'd1);
        chk("lit_count_63", 0, 128'(cnt0), 128'd63);
        chk("lit_dout_101", 0, 128'(dout0), 128'h101);

        // Flush with a concurrent write at count 10
        cyc(0, 0, 0, '0, 1);
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, 128'(32'h200 + i), 0);
        cyc(0, 1, 0, 128'h999, 1);
        chk("lit_flush_cnt", 0, 128'(cnt0), 128'd0);
        chk("lit_flush_empty", 0, 128'(o_empty[0]), 128'd1);
        chk("lit_flush_dout", 0, 128'(dout0), 128'd0);
        cyc(0, 1, 0, 128'h55, 0);
        chk("lit_after_flush", 0, 128'(dout0), 128'h55);

        // Upsize packing
        cyc(1, 1, 0, 128'h11, 0);
        cyc(1, 1, 0, 128'h22, 0);
        cyc(1, 1, 0, 128'h33, 0);
        chk("lit_up_empty", 1, 128'(o_empty[1]), 128'd1);
        chk("lit_up_cnt0", 1, 128'(cnt1), 128'd0);
        cyc(1, 1, 0, 128'h44, 0);
        chk("lit_up_dout", 1, dout1, 128'h00000044_00000033_00000022_00000011);
        chk("lit_up_cnt1", 1, 128'(cnt1), 128'd1);

        // Asynchronous reset after two staged words
        cyc(1, 1, 0, 128'hA1, 0);
        cyc(1, 1, 0, 128'hA2, 0);
        #2 rst_a[1] = 0;
        #1;
        chk("lit_arst_empty", 1, 128'(o_empty[1]), 128'd1);
        chk("lit_arst_cnt", 1, 128'(cnt1), 128'd0);
        chk("lit_arst_dout", 1, dout1, 128'd0);
        @(posedge clk); #3 rst_a[1] = 1;
        @(posedge clk); #1;
        for (int i = 1; i <= 4; i++) cyc(1, 1, 0, 128'(32'hB0 + i), 0);
        chk("lit_up_fresh", 1, dout1, 128'h000000B4_000000B3_000000B2_000000B1);
        chk("lit_up_fresh_cnt", 1, 128'(cnt1), 128'd1);
        cyc(1, 0, 1, '0, 0);
        chk("lit_up_drained", 1, 128'(o_empty[1]), 128'd1);
        for (int i = 0; i < 17; i++) cyc(1, 1, 0, 128'(32'hC00 + i), 0);
        chk("lit_up_full", 1, 128'(o_full[1]), 128'd1);
        chk("lit_up_ovf", 1, 128'(o_ov[1]), 128'd1);
        cyc(1, 0, 1, '0, 0);
        chk("lit_up_head", 1, dout1, 128'h00000C07_00000C06_00000C05_00000C04);

        // Downsize unpacking
        cyc(2, 1, 0, 128'h0D0C0B0A_09080706_05040302_01000F0E, 0);
        chk("lit_dn_w0", 2, 128'(dout2), 128'h01000F0E);
        cyc(2, 0, 1, '0, 0);
        chk("lit_dn_w1", 2, 128'(dout2), 128'h05040302);
        cyc(2, 0, 1, '0, 0);
        chk("lit_dn_w2", 2, 128'(dout2), 128'h09080706);
        cyc(2, 0, 1, '0, 0);
        chk("lit_dn_w3", 2, 128'(dout2), 128'h0D0C0B0A);
        chk("lit_dn_cnt1", 2, 128'(cnt2), 128'd1);
        cyc(2, 0, 1, '0, 0);
        chk("lit_dn_cnt0", 2, 128'(cnt2), 128'd0);
        chk("lit_dn_empty", 2, 128'(o_empty[2]), 128'd1);
        cyc(2, 0, 1, '0, 0);
        chk("lit_dn_unf", 2, 128'(o_un[2]), 128'd1);
        for (int i = 0; i < 9; i++) cyc(2, 1, 0, {4{32'(i + 1)}}, 0);
        chk("lit_dn_full", 2, 128'(o_full[2]), 128'd1);
        for (int i = 0; i < 6; i++) cyc(2, 0, 1, '0, 0);
        chk("lit_dn_mid", 2, 128'(dout2), 128'd2);

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout t=%0t actual=running required=finished", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fifo_sync_wconv.md
Name: fifo_sync_wconv

Overview:
- Single-clock, parametrised FIFO with integer-ratio width conversion, first-word-fall-through (FWFT) read, programmable thresholds, occupancy count and sticky error flags.
- Upsize example: 32-bit words packed into 256-bit blocks for the miner core.
- Downsize example: 256-bit digests unpacked to 32-bit words for the host-side path.
- Used wherever producer and consumer share one clock, replacing the async macro on same-clock paths.

Parameters:
- DEPTH, 64: storage entries of width MEM_W = max(WR_WIDTH, RD_WIDTH); power of 2, at least 4.
- WR_WIDTH, 32: din width.
- RD_WIDTH, 32: dout width. One of WR_WIDTH and RD_WIDTH is a power-of-2 multiple of the other. RATIO = MEM_W / min(WR_WIDTH, RD_WIDTH).
- PROG_FULL_THRESH, 48: prog_full asserts when count >= this value; range 1..DEPTH.
- PROG_EMPTY_THRESH, 4: prog_empty asserts when count <= this value; range 0..DEPTH-1.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous assert, active-low
- flush  in  1  synchronous clear of contents, staging and counters
- wr_en  in  1  write strobe
- din  in  WR_WIDTH  write data
- full  out  1  no entry space
- rd_en  in  1  read/acknowledge of the current dout
- dout  out  RD_WIDTH  FWFT head data
- empty  out  1  no readable data
- count  out  $clog2(DEPTH)+1  complete entries stored
- prog_full  out  1  count >= PROG_FULL_THRESH
- prog_empty  out  1  count <= PROG_EMPTY_THRESH
- overflow  out  1  sticky: wr_en while full
- underflow  out  1  sticky: rd_en while empty

Behaviour:
- Reset (rst_n=0, asynchronous): pointers, count, staging, slice index and sticky flags are cleared.
  - Output values during reset: full=0, empty=1, prog_full=0, prog_empty=1, overflow=0, underflow=0, count=0, dout=0.
  - Memory contents are not reset.
- Reset or flush mid-operation discards all data, including partial staging or slice state.
- flush has priority over wr_en and rd_en in the same cycle. Outputs equal their reset values on the next cycle. Sticky flags are cleared.
- Accepted write: wr_en & ~full. Accepted read: rd_en & ~empty. full = (count==DEPTH); empty = (count==0). All flags are registered from next-state count.
- Equal widths (RATIO=1):
  - An accepted write stores din at wr_ptr.
  - dout = mem[rd_ptr] combinationally (FWFT).
  - Write-to-dout latency is 1 cycle: empty falls the cycle after the first write.
- Upsize (WR_WIDTH < RD_WIDTH):
  - Accepted writes fill a staging register LSB-first; a word index counts 0..RATIO-1.
  - The RATIO-th write pushes {din, staging} into memory as one entry. Only complete entries are counted or readable.
  - full blocks all writes, including writes into staging, whenever count==DEPTH.
- Downsize (WR_WIDTH > RD_WIDTH):
  - dout = slice[s] of the head entry, with s = 0..RATIO-1, LSB slice first.
  - An accepted read increments s. The read at s=RATIO-1 pops the entry and resets s to 0.
  - count, empty and prog_empty change only on pops.
- Simultaneous push and pop: count is unchanged and both pointers advance.
  - At count==DEPTH the write is rejected (full is registered) and the pop proceeds.
  - At count==0 the read is rejected and the write proceeds.
- Pointers wrap modulo DEPTH. count is computed explicitly, not from pointer difference ambiguity.
- Rejected write sets overflow; rejected read sets underflow. Both hold until reset or flush. Rejected operations alter no other state.
- Single read port, no output register. dout changes only on an accepted read, a write into empty, flush or reset.

Test Plan:
- Defaults, reset, write 0x1..0x40 back-to-back:
  - full rises after the 64th write and count=64; prog_full rises when count reaches 48.
  - A 65th write with din=0xDEAD sets overflow and is not stored.
  - Draining returns 0x1..0x40 in order; empty rises after the 64th read and prog_empty is asserted at count<=4.
- Upsize WR=32, RD=128, DEPTH=4: write 0x11,0x22,0x33 -> empty stays 1 and count=0. Write 0x44 -> next cycle empty=0, dout=0x00000044_00000033_00000022_00000011, count=1.
- Downsize WR=128, RD=32: write 0x0D0C0B0A_... (words W3..W0) -> four reads return W0, W1, W2, W3. count falls 1->0 only on the 4th read, and empty rises the next cycle.
- At count=64, assert wr_en and rd_en together -> read accepted, write rejected with overflow=1, count=63. At count=0, assert both together -> write accepted, read rejected with underflow=1, count=1.
- Pulse rst_n low asynchronously mid-stream, after 2 of 4 upsize words -> outputs take reset values immediately. A new 4-word sequence after release produces exactly one correct entry, with no stale words.
- flush with wr_en=1 at count=10 -> next cycle count=0, empty=1 and flags cleared; the flush-cycle write is discarded.
